// File: rtl/alu_pkg.sv
// Definitions shared across the lab ALU datapath: the serial subtractor's FSM
// states and the default datapath width.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sub_state_t;

  localparam int unsigned ALU_W = 8;

endpackage : alu_pkg

// File: rtl/add1b.sv
// 1-bit full-adder cell: r = a ^ b ^ ci, with the majority function as carry out.
module add1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic r,
  output logic co
);

  assign r  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule : add1b

// File: rtl/sub_serial.sv
// Bit-serial two's-complement subtractor: diff = a + ~b + 1, LSB first, through
// a single full-adder slice with a registered carry. Reports borrow and signed overflow.
module sub_serial
  import alu_pkg::*;
#(
  parameter int unsigned W = ALU_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow,
  output logic         ovf
);

  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  sub_state_t    state_q, state_d;
  logic [W-1:0]  sa_q, sa_d;
  logic [W-1:0]  sb_q, sb_d;
  logic [W-1:0]  diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          borrow_q, borrow_d;
  logic          ovf_q, ovf_d;

  logic          slice_s;
  logic          slice_co;

  add1b u_slice (
    .a  (sa_q[0]),
    .b  (sb_q[0]),
    .ci (carry_q),
    .r  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d     = a;
          sb_d     = ~b;
          carry_d  = 1'b1;
          cnt_d    = '0;
          diff_d   = '0;
          borrow_d = 1'b0;
          ovf_d    = 1'b0;
          state_d  = RUN;
        end
      end

      RUN: begin
        diff_d  = {slice_s, diff_q[W-1:1]};
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        carry_d = slice_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // carry_q is the carry into the MSB here, so no separate cprev flop is kept.
          borrow_d = ~slice_co;
          ovf_d    = carry_q ^ slice_co;
          cnt_d    = '0;
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule : sub_serial

// File: doc/sub_serial.md
# sub_serial

Bit-serial two's-complement subtractor for the lab ALU datapath. Computes `diff = a - b` over `W` bits, one bit per clock, LSB first, as `a + ~b + 1` through a single 1-bit full-adder slice with a registered carry. It trades latency for area beside the parallel ripple adder and reports unsigned borrow and signed overflow. A start/done handshake connects it to the ALU controller.

## Interface

Parameters:
- `W`, default 8: operand and result width; legal range 2 to 32.

Ports:
- `clk`, input, 1: the only clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `start`, input, 1: request an operation; honoured only in IDLE.
- `a`, input, `W`: minuend; sampled on the accepting edge only.
- `b`, input, `W`: subtrahend; sampled on the accepting edge only.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: one-cycle pulse in DONE; results are valid from this cycle on.
- `diff`, output, `W`: the result `a - b` mod 2^W.
- `borrow`, output, 1: high when `a < b` as unsigned values; equals the inverted final carry.
- `ovf`, output, 1: signed overflow; equals the carry into the MSB XOR the carry out of the MSB.

## Operation

State machine: IDLE, RUN, DONE.

IDLE:
- When `start`=1, load `a` into shift register `sa` and `~b` into shift register `sb`.
- Set `carry`=1, bit counter `cnt`=0, and go to RUN.
- `diff`, `borrow` and `ovf` keep their previous values until the load edge, then clear to 0.

RUN, on each edge:
- The slice computes `s` and `co` from `sa[0]`, `sb[0]` and `carry`.
- `s` shifts into `diff` at the MSB, with `diff` shifting right.
- `sa` and `sb` shift right. `carry` takes `co`. `cnt` increments.
- `cprev` takes the old `carry`; this is the carry into the current bit.
- On the edge where `cnt`=W-1:
  - `borrow` takes `~co` and `ovf` takes `cprev XOR co`, where `cprev` here means the carry into the MSB, i.e. the value of `carry` before this edge.
  - Go to DONE.

DONE:
- `done`=1 for exactly one cycle.
- Unconditionally return to IDLE. `start` is ignored in this cycle.

Boundary conditions:
- `start` in RUN or DONE is ignored, with no queuing. Operands may change freely after acceptance.
- Reset at any point, including mid-RUN, aborts the operation. It returns to IDLE with every register zeroed and no `done` pulse.
- `cnt` width is `$clog2(W)`; it never wraps inside one operation.
- `b`=0: `diff`=`a`, `borrow`=0, and `ovf`=0, because the carry-in of 1 propagates through every bit.

## Timing

- Reset values: `busy`=0, `done`=0, `diff`=0, `borrow`=0, `ovf`=0; state is IDLE, `cnt`=0, `carry`=0.
- Call the edge that accepts `start` edge 0. `busy` goes high after edge 0. Bits are processed on edges 1..W.
- After edge W: `busy`=0 and `done`=1. After edge W+1: `done`=0 and state is IDLE.
- Minimum start-to-start spacing is W+2 cycles.
- Results hold from `done` until the next accepting edge.
- All outputs are registered; there is no combinational path from input to output.

## Structure

- Shared package `alu_pkg` holds:
  - enum `sub_state_t` {IDLE, RUN, DONE};
  - constant `ALU_W` = 8, the default for `W`.
- Sub-module: the team's 1-bit full-adder cell `add1b` (ports `a`, `b`, `ci`, `r`, `co`), instantiated once as the serial slice.
- Everything else lives in `sub_serial`: FSM, shift registers, counter and flag logic.

## Test plan

All scenarios use W=8.

1. 0x05 − 0x03 → `diff`=0x02, `borrow`=0, `ovf`=0; `done` appears exactly 8 edges after the accepting edge and lasts one cycle.
2. 0x03 − 0x05 → `diff`=0xFE, `borrow`=1, `ovf`=0.
3. Signed overflow cases:
   - 0x80 − 0x01 → `diff`=0x7F, `borrow`=0, `ovf`=1.
   - 0x7F − 0xFF → `diff`=0x80, `borrow`=1, `ovf`=1.
4. Start while busy: start 0x0A − 0x04; pulse `start` with 0xFF − 0x00 on edge 3 → first result 0x06 is unaffected, only one `done` occurs, and the second request is dropped.
5. Reset during RUN: start 0x55 − 0x11; drive `rst_n`=0 on edge 4 → after that edge all outputs are 0 and the FSM is in IDLE, with no `done`. A following 0x00 − 0x00 gives `diff`=0x00, `borrow`=0, `ovf`=0.
6. Back-to-back operations: issue `start` on the first IDLE cycle after each `done`, for 20 random operand pairs → every result matches the model `a - b`, and spacing is exactly 10 cycles.
